// File: rtl/alu_op_sequencer.sv
//-----------------------------------------------------------------------------
// alu_op_sequencer
//
// Control stage that sits directly in front of the 16:1 ALU result mux.
// It takes one operation at a time (opcode plus two operands) over a
// valid/ready request port and registers the operands and the mux select
// into the datapath. It then waits SETTLE cycles for the ALU to settle,
// captures the mux output together with zero/negative flags, and holds the
// result on a valid/ready response port until the consumer takes it.
//
// Parameters:
//   WIDTH  - operand/result width; must match the mux data width.
//   SEL_W  - select-line width (2**SEL_W mux inputs).
//   SETTLE - cycles from driving operands/select to capturing alu_y (1..15).
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (req_ready only in IDLE)
//   req_op/req_a/req_b  - opcode and operands of the request
//   req_use_acc         - (ALU_SEQ_ACCUMULATE_EN only) take A from accumulator
//   alu_a/alu_b         - registered operands to the ALU units
//   selectLine          - registered mux select
//   alu_y               - mux output from the ALU datapath
//   rsp_valid/rsp_ready - response handshake
//   rsp_result          - captured result
//   rsp_zero/rsp_neg    - result == 0 / result sign bit
//   busy                - an operation is in flight (state != IDLE)
//
// Optional feature (macro ALU_SEQ_ACCUMULATE_EN):
//   Adds req_use_acc and an accumulator loaded with each retired result, so
//   chained operations can take operand A from the previous result.
//-----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int WIDTH  = 8,
   parameter int SEL_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SEL_W-1:0] req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SEQ_ACCUMULATE_EN
   input  logic             req_use_acc,
`endif
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] selectLine,
   input  logic [WIDTH-1:0] alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_neg,
   output logic             busy
);

   // Illegal settle times are rejected at elaboration rather than silently
   // producing a zero-width or wrapping counter.
   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("alu_op_sequencer: SETTLE must be in the range 1..15");
      end
   endgenerate

   // Counter is wide enough to hold SETTLE itself, so the final increment on
   // the capture edge never wraps.
   localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] w_a_next;

`ifdef ALU_SEQ_ACCUMULATE_EN
   logic [WIDTH-1:0] r_acc;

   assign w_a_next = req_use_acc ? r_acc : req_a;
`else
   assign w_a_next = req_a;
`endif

   // Ready is combinational from the registered state so a new request can be
   // taken in the first cycle after reset; it is masked while reset is high.
   assign req_ready = (r_state == S_IDLE) && !reset;
   assign busy      = (r_state != S_IDLE);

   // NOTE: every register here, outputs included, is assigned with <= so all
   // of them update together on the edge; a blocking = would let later
   // statements see the new value within the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         selectLine <= '0;
         rsp_result <= '0;
         rsp_valid  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_neg    <= 1'b0;
`ifdef ALU_SEQ_ACCUMULATE_EN
         r_acc      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               // req_ready is 1 whenever we are here and reset is low.
               if (req_valid) begin
                  alu_a      <= w_a_next;
                  alu_b      <= req_b;
                  selectLine <= req_op;
                  r_count    <= '0;
                  r_state    <= S_EXEC;
               end
            end

            S_EXEC: begin
               r_count <= r_count + CNT_W'(1);
               // Operands and select have been stable for SETTLE edges when the
               // count reaches SETTLE-1, so alu_y is sampled on this edge.
               if (r_count == LAST_CNT) begin
                  rsp_result <= alu_y;
                  rsp_zero   <= (alu_y == '0);
                  rsp_neg    <= alu_y[WIDTH-1];
                  rsp_valid  <= 1'b1;
                  r_state    <= S_DONE;
               end
            end

            S_DONE: begin
               // Response is held unchanged for as long as the consumer stalls.
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
`ifdef ALU_SEQ_ACCUMULATE_EN
                  r_acc     <= rsp_result;
`endif
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
//-----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Two sequencer instances: u_dut1 (SETTLE=1) takes directed and random
// traffic, u_dut4 (SETTLE=4) covers the multi-cycle settle window and reset
// in the middle of an operation. Expected responses are pushed into a queue
// when a request is accepted; a monitor per instance pops and compares them
// whenever a response is handed over.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_ACCUMULATE_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] res;
      logic       zero;
      logic       neg;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance with SETTLE=1 ----------------
   logic       reset1, req_valid1, req_ready1, use_acc1;
   logic [3:0] req_op1, sel1;
   logic [7:0] req_a1, req_b1, alu_a1, alu_b1, alu_y1, rsp_result1;
   logic       rsp_valid1, rsp_ready1, rsp_zero1, rsp_neg1, busy1;

   // ---------------- instance with SETTLE=4 ----------------
   logic       reset4, req_valid4, req_ready4, use_acc4;
   logic [3:0] req_op4, sel4;
   logic [7:0] req_a4, req_b4, alu_a4, alu_b4, alu_y4, rsp_result4;
   logic       rsp_valid4, rsp_ready4, rsp_zero4, rsp_neg4, busy4;
   logic       y4_force_en;
   logic [7:0] y4_force;

   exp_t       q1[$];
   exp_t       q4[$];
   logic [7:0] acc1;          // model of the accumulator: last retired result
   int         rdy_mode;      // 0 random, 1 held low, 2 held high
   logic       hold_pending1;
   logic [7:0] hold_val1;
   logic       hold_z1, hold_n1;

   // Bench-side ALU: the behaviour behind the 16:1 mux for the opcodes used.
   function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      case (op)
         4'h0:    return a & b;
         4'h1:    return a | b;
         4'h2:    return a ^ b;
         4'h3:    return a + b;
         4'h5:    return a - b;
         4'hA:    return ~a;
         default: return a;
      endcase
   endfunction

   assign alu_y1 = alu_fn(sel1, alu_a1, alu_b1);
   assign alu_y4 = y4_force_en ? y4_force : alu_fn(sel4, alu_a4, alu_b4);

   alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .SETTLE(1)) u_dut1 (
      .clk        (clk),
      .reset      (reset1),
      .req_valid  (req_valid1),
      .req_ready  (req_ready1),
      .req_op     (req_op1),
      .req_a      (req_a1),
      .req_b      (req_b1),
`ifdef ALU_SEQ_ACCUMULATE_EN
      .req_use_acc(use_acc1),
`endif
      .alu_a      (alu_a1),
      .alu_b      (alu_b1),
      .selectLine (sel1),
      .alu_y      (alu_y1),
      .rsp_valid  (rsp_valid1),
      .rsp_ready  (rsp_ready1),
      .rsp_result (rsp_result1),
      .rsp_zero   (rsp_zero1),
      .rsp_neg    (rsp_neg1),
      .busy       (busy1)
   );

   alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .SETTLE(4)) u_dut4 (
      .clk        (clk),
      .reset      (reset4),
      .req_valid  (req_valid4),
      .req_ready  (req_ready4),
      .req_op     (req_op4),
      .req_a      (req_a4),
      .req_b      (req_b4),
`ifdef ALU_SEQ_ACCUMULATE_EN
      .req_use_acc(use_acc4),
`endif
      .alu_a      (alu_a4),
      .alu_b      (alu_b4),
      .selectLine (sel4),
      .alu_y      (alu_y4),
      .rsp_valid  (rsp_valid4),
      .rsp_ready  (rsp_ready4),
      .rsp_result (rsp_result4),
      .rsp_zero   (rsp_zero4),
      .rsp_neg    (rsp_neg4),
      .busy       (busy4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got timeout/unexpected event, expected the handshake", name);
   endtask

   // rsp_ready driver for u_dut1
   initial begin
      rsp_ready1 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready1 = ($urandom_range(0, 3) != 0);
            1:       rsp_ready1 = 1'b0;
            default: rsp_ready1 = 1'b1;
         endcase
      end
   end

   // Monitor for u_dut1: compares on handover, checks hold under backpressure.
   exp_t m1;
   always @(negedge clk) begin
      if (!reset1) begin
         if (rsp_valid1) begin
            check("no_ready_while_rsp", req_ready1, 1'b0);
            if (hold_pending1) begin
               check("hold_result", rsp_result1, hold_val1);
               check("hold_flags", {rsp_zero1, rsp_neg1}, {hold_z1, hold_n1});
            end
            if (rsp_ready1) begin
               if (q1.size() == 0) begin
                  fail("rsp1_unexpected");
               end else begin
                  m1 = q1.pop_front();
                  check("rsp1_result", rsp_result1, m1.res);
                  check("rsp1_zero", rsp_zero1, m1.zero);
                  check("rsp1_neg", rsp_neg1, m1.neg);
                  acc1 = m1.res;
               end
               hold_pending1 = 1'b0;
            end else begin
               hold_pending1 = 1'b1;
               hold_val1     = rsp_result1;
               hold_z1       = rsp_zero1;
               hold_n1       = rsp_neg1;
            end
         end else if (hold_pending1) begin
            check("rsp1_valid_held", rsp_valid1, 1'b1);
            hold_pending1 = 1'b0;
         end
      end
   end

   // Monitor for u_dut4
   exp_t m4;
   always @(negedge clk) begin
      if (!reset4 && rsp_valid4) begin
         if (q4.size() == 0) begin
            fail("rsp4_unexpected");
         end else if (rsp_ready4) begin
            m4 = q4.pop_front();
            check("rsp4_result", rsp_result4, m4.res);
            check("rsp4_zero", rsp_zero4, m4.zero);
            check("rsp4_neg", rsp_neg4, m4.neg);
         end
      end
   end

   // Issue one request to u_dut1 and record what it must answer.
   task automatic send1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic use_acc);
      exp_t       e;
      logic [7:0] a_eff;
      int         n;
      @(posedge clk);
      #1;
      req_op1    = op;
      req_a1     = a;
      req_b1     = b;
      use_acc1   = use_acc;
      req_valid1 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready1) begin
         req_valid1 = 1'b0;
         fail("send1_accept_timeout");
         return;
      end
      a_eff  = (ACC_EN && use_acc) ? acc1 : a;
      e.res  = alu_fn(op, a_eff, b);
      e.zero = (e.res == 8'h00);
      e.neg  = e.res[7];
      @(posedge clk);                      // accept edge
      q1.push_back(e);
      #1;
      req_valid1 = 1'b0;
      req_op1    = 4'($urandom);
      req_a1     = 8'($urandom);
      req_b1     = 8'($urandom);
      @(negedge clk);
      check("accept_sel", sel1, op);
      check("accept_alu_a", alu_a1, a_eff);
      check("accept_alu_b", alu_b1, b);
      check("accept_busy", busy1, 1'b1);
      check("exec_no_valid", rsp_valid1, 1'b0);
      @(negedge clk);
      check("latency_valid", rsp_valid1, 1'b1);
   endtask

   logic [7:0] yv[4];
   logic [3:0] ops[8];
   exp_t       e4;

   initial begin
      yv  = '{8'h11, 8'h22, 8'h33, 8'h44};
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'hA, 4'h7, 4'hF};
      reset1 = 1'b1; reset4 = 1'b1;
      req_valid1 = 1'b0; req_op1 = '0; req_a1 = '0; req_b1 = '0; use_acc1 = 1'b0;
      req_valid4 = 1'b0; req_op4 = '0; req_a4 = '0; req_b4 = '0; use_acc4 = 1'b0;
      rsp_ready4 = 1'b0; y4_force_en = 1'b0; y4_force = '0;
      acc1 = '0; hold_pending1 = 1'b0; hold_val1 = '0; hold_z1 = 1'b0; hold_n1 = 1'b0;
      rdy_mode = 2;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", req_ready1, 1'b0);
      @(posedge clk);
      #1;
      reset1 = 1'b0; reset4 = 1'b0;
      @(negedge clk);
      check("rst_ready", req_ready1, 1'b1);
      check("rst_busy", busy1, 1'b0);
      check("rst_ops", {alu_a1, alu_b1, sel1}, 20'h0);
      check("rst_rsp", {rsp_valid1, rsp_result1, rsp_zero1, rsp_neg1}, 11'h0);
      check("rst4_ready", req_ready4, 1'b1);
      check("rst4_rsp", {rsp_valid4, rsp_result4, busy4}, 10'h0);

      // ---- add, single-cycle settle, retire then ready ----
      send1(4'h3, 8'h0F, 8'h01, 1'b0);
      check("t1_result", rsp_result1, 8'h10);
      @(negedge clk);
      check("t1_ready_after_retire", req_ready1, 1'b1);
      check("t1_valid_cleared", rsp_valid1, 1'b0);

      // ---- subtract: zero and negative flags ----
      send1(4'h5, 8'h22, 8'h22, 1'b0);
      check("t2_zero", rsp_zero1, 1'b1);
      send1(4'h5, 8'h01, 8'h02, 1'b0);
      check("t2_neg", {rsp_result1, rsp_zero1, rsp_neg1}, {8'hFF, 1'b0, 1'b1});
      @(negedge clk);

      // ---- backpressure with a competing request ----
      rdy_mode = 1;
      send1(4'h3, 8'h40, 8'h41, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         req_valid1 = (i % 2 == 0);
         req_op1    = 4'hA;
         req_a1     = 8'($urandom);
         @(negedge clk);
         check("bp_ready_low", req_ready1, 1'b0);
         check("bp_valid_high", rsp_valid1, 1'b1);
         check("bp_result", {rsp_result1, rsp_zero1, rsp_neg1}, {8'h81, 1'b0, 1'b1});
         check("bp_sel_unchanged", sel1, 4'h3);
      end
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      rdy_mode   = 2;
      repeat (3) @(negedge clk);

      // ---- accumulator chaining (only with the feature built in) ----
      if (ACC_EN) begin
         send1(4'h3, 8'h05, 8'h03, 1'b0);
         send1(4'h3, 8'hEE, 8'h02, 1'b1);
         check("acc_result", rsp_result1, 8'h0A);
         @(negedge clk);
      end

      // ---- random traffic with random backpressure ----
      rdy_mode = 0;
      for (int i = 0; i < 40; i++) begin
         send1(ops[$urandom_range(0, 7)], 8'($urandom), 8'($urandom), 1'($urandom));
      end
      @(negedge clk);
      rdy_mode = 2;
      for (int n = 0; n < 50 && (q1.size() != 0 || rsp_valid1); n++) @(negedge clk);
      if (q1.size() != 0 || rsp_valid1) fail("drain1_timeout");

      // ---- SETTLE=4: alu_y changes during EXEC, last value captured ----
      @(posedge clk);
      #1;
      req_op4 = 4'h3; req_a4 = 8'h01; req_b4 = 8'h02; req_valid4 = 1'b1;
      @(negedge clk);
      check("s4_ready_idle", req_ready4, 1'b1);
      @(posedge clk);                      // accept edge
      e4.res = yv[3]; e4.zero = 1'b0; e4.neg = 1'b0;
      q4.push_back(e4);
      #1;
      req_valid4  = 1'b0;
      y4_force_en = 1'b1;
      y4_force    = yv[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("s4_exec_no_valid", rsp_valid4, 1'b0);
         check("s4_busy_exec", busy4, 1'b1);
         check("s4_ops_stable", {sel4, alu_a4, alu_b4}, {4'h3, 8'h01, 8'h02});
         @(posedge clk);
         #1;
         y4_force = (k < 3) ? yv[k + 1] : 8'h99;
      end
      @(negedge clk);
      check("s4_valid_after_4", rsp_valid4, 1'b1);
      check("s4_result_held", rsp_result4, 8'h44);
      check("s4_busy_done", busy4, 1'b1);
      @(posedge clk);
      #1;
      rsp_ready4 = 1'b1;
      @(negedge clk);
      @(posedge clk);                      // retire edge
      #1;
      rsp_ready4 = 1'b0;
      @(negedge clk);
      check("s4_ready_after_retire", req_ready4, 1'b1);
      check("s4_idle", {busy4, rsp_valid4}, 2'b00);

      // ---- SETTLE=4: reset in the middle of EXEC drops the operation ----
      y4_force_en = 1'b0;
      @(posedge clk);
      #1;
      req_op4 = 4'h3; req_a4 = 8'h07; req_b4 = 8'h08; req_valid4 = 1'b1;
      @(negedge clk);
      @(posedge clk);                      // accept edge
      #1;
      req_valid4 = 1'b0;
      rsp_ready4 = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", busy4, 1'b1);
      @(posedge clk);
      #1;
      reset4 = 1'b1;
      @(negedge clk);
      check("rst_mid_ready_low", req_ready4, 1'b0);
      @(posedge clk);                      // reset edge
      #1;
      reset4 = 1'b0;
      @(negedge clk);
      check("rst_mid_ready", req_ready4, 1'b1);
      check("rst_mid_zero", {alu_a4, alu_b4, sel4, rsp_result4}, 28'h0);
      check("rst_mid_flags", {rsp_valid4, rsp_zero4, rsp_neg4, busy4}, 4'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("dropped_no_rsp", rsp_valid4, 1'b0);
      end

      // ---- SETTLE=4: normal operation after the dropped one ----
      @(posedge clk);
      #1;
      req_op4 = 4'h5; req_a4 = 8'h09; req_b4 = 8'h03; req_valid4 = 1'b1;
      @(negedge clk);
      @(posedge clk);                      // accept edge
      e4.res = alu_fn(4'h5, 8'h09, 8'h03); e4.zero = (e4.res == 8'h00); e4.neg = e4.res[7];
      q4.push_back(e4);
      #1;
      req_valid4 = 1'b0;
      for (int n = 0; n < 20 && q4.size() != 0; n++) @(negedge clk);
      if (q4.size() != 0) fail("drain4_timeout");
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control stage directly upstream of the 16:1 8-bit ALU result mux.
- Accepts one operation request (opcode plus two operands) over a valid/ready handshake, drives the operand buses and the 4-bit `selectLine` into the ALU datapath, and waits a fixed settle time.
- Captures the mux output `y`, derives zero/negative flags and holds the result on a valid/ready response port until it is consumed.
- Serialises ALU use: one operation in flight.

Parameters:
- WIDTH, 8, operand/result width; must match the mux data width.
- SEL_W, 4, select-line width; 2**SEL_W mux inputs.
- SETTLE, 1, cycles between driving operands/select and capturing `alu_y`; legal range 1..15. SETTLE=0 is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  SEL_W  opcode; becomes `selectLine`.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  registered operand A to the ALU units.
- alu_b  out  WIDTH  registered operand B to the ALU units.
- selectLine  out  SEL_W  registered mux select.
- alu_y  in  WIDTH  mux output `y`.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  `rsp_result` == 0.
- rsp_neg  out  1  `rsp_result[WIDTH-1]`.
- busy  out  1  state != IDLE.

Behaviour:
- Single clock; reset is synchronous and active-high. On the reset edge, regardless of state:
  - state=IDLE, count=0.
  - `alu_a`, `alu_b`, `selectLine`, `rsp_result` = 0.
  - `rsp_valid`, `rsp_zero`, `rsp_neg`, `busy` = 0.
- `req_ready` = (state==IDLE) && !reset. It is combinational from registered state, so it is 1 in the first cycle after reset.
- States:
  - IDLE:
    - On edge with `req_valid && req_ready`: latch `req_a`→`alu_a`, `req_b`→`alu_b`, `req_op`→`selectLine`; count←0; go to EXEC.
  - EXEC:
    - Each edge: count←count+1.
    - On the edge where count==SETTLE-1: `rsp_result`←`alu_y`, `rsp_zero`←(`alu_y`==0), `rsp_neg`←`alu_y[WIDTH-1]`, `rsp_valid`←1; go to DONE.
  - DONE:
    - Hold `rsp_*` stable while `rsp_ready`=0; backpressure is unbounded.
    - On edge with `rsp_valid && rsp_ready`: `rsp_valid`←0; go to IDLE.
- Latency, counted from the accept edge E0: `rsp_valid` is high after edge E0+SETTLE. With SETTLE=1 it rises one cycle after accept.
- Throughput: one op per SETTLE+2 cycles minimum. No accept occurs in the same cycle as response retirement.
- `alu_a`, `alu_b` and `selectLine` hold their last values after completion. They change only on accept or reset, so they are stable for the full EXEC window.
- `req_valid` asserted in EXEC or DONE is ignored: `req_ready`=0 and no state change. The requester must hold the request.
- `rsp_ready` in IDLE or EXEC has no effect.
- Reset mid-EXEC or mid-DONE: the operation is dropped and no response is produced.
- The counter is sized `$clog2(SETTLE+1)` bits and never wraps; it is only compared against SETTLE-1.

Optional Feature:
- Macro: ALU_SEQ_ACCUMULATE_EN.
- Defined:
  - Adds input port `req_use_acc` (1 bit) and an internal WIDTH-bit accumulator, reset to 0.
  - The accumulator is loaded with `rsp_result` on the response-retire handshake.
  - On accept with `req_use_acc`=1, `alu_a`←accumulator instead of `req_a`; `req_b` is unaffected.
  - Enables chained ops without the host re-supplying A.
- Undefined: no `req_use_acc` port, no accumulator; `alu_a` always ← `req_a`.

Test Plan:
- SETTLE=1, bench ALU model y=a+b for op 4'h3. Send op=3, a=8'h0F, b=8'h01 → `selectLine`=3, `alu_a`=0F, `alu_b`=01 the cycle after accept. `rsp_valid` high the next cycle with result 8'h10, zero=0, neg=0. `req_ready` returns to 1 the cycle after `rsp_ready` handshake.
- Model op 4'h5 = a−b. Send a=8'h22, b=8'h22 → result 8'h00, zero=1. Then a=8'h01, b=8'h02 → result 8'hFF, neg=1, zero=0.
- Hold `rsp_ready`=0 for 6 cycles after `rsp_valid`; toggle `req_valid` with new op 4'hA → `rsp_result` and flags unchanged, `req_ready`=0 throughout, new op not latched.
- SETTLE=4: change `alu_y` model output on each EXEC cycle (11,22,33,44) → captured result = 44. `rsp_valid` rises exactly 4 cycles after accept; `busy` high from accept until retire.
- Assert reset during EXEC (SETTLE=4, cycle 2) → next cycle all outputs 0, `req_ready`=1, no `rsp_valid` pulse ever appears for the dropped op.
- With ALU_SEQ_ACCUMULATE_EN, op add: first a=8'h05, b=8'h03 → 8'h08. Second `req_use_acc`=1, a=8'hEE, b=8'h02 → `alu_a`=8'h08, result 8'h0A.
